// File: rtl/shreg_pkg.sv
// Shared types for the universal shift register: operation modes and burst FSM states.
package shreg_pkg;

   typedef enum logic [2:0] {
      HOLD  = 3'd0,
      SHL   = 3'd1,
      SHR   = 3'd2,
      ROL   = 3'd3,
      ROR   = 3'd4,
      ASR   = 3'd5,
      LOAD  = 3'd6,
      CLEAR = 3'd7
   } shreg_mode_e;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } shreg_state_e;

endpackage

// File: rtl/shreg_step_unit.sv
// Combinational next-value unit: computes one STEP-bit operation on the current
// register contents, plus the bits pushed out and whether sout should take them.
module shreg_step_unit
   import shreg_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int STEP  = 1
) (
   input  logic [WIDTH-1:0] cur_i,
   input  shreg_mode_e      mode_i,
   input  logic [STEP-1:0]  din_i,
   input  logic [WIDTH-1:0] pdata_i,
   output logic [WIDTH-1:0] nxt_o,
   output logic [STEP-1:0]  sout_o,
   output logic             sout_upd_o
);

   // Select the operation; HOLD/LOAD/CLEAR leave sout alone.
   always_comb begin
      nxt_o      = cur_i;
      sout_o     = cur_i[STEP-1:0];
      sout_upd_o = 1'b0;
      case (mode_i)
         SHL: begin
            nxt_o      = {cur_i[WIDTH-STEP-1:0], din_i};
            sout_o     = cur_i[WIDTH-1 -: STEP];
            sout_upd_o = 1'b1;
         end
         SHR: begin
            nxt_o      = {din_i, cur_i[WIDTH-1:STEP]};
            sout_o     = cur_i[STEP-1:0];
            sout_upd_o = 1'b1;
         end
         ROL: begin
            nxt_o      = {cur_i[WIDTH-STEP-1:0], cur_i[WIDTH-1 -: STEP]};
            sout_o     = cur_i[WIDTH-1 -: STEP];
            sout_upd_o = 1'b1;
         end
         ROR: begin
            nxt_o      = {cur_i[STEP-1:0], cur_i[WIDTH-1:STEP]};
            sout_o     = cur_i[STEP-1:0];
            sout_upd_o = 1'b1;
         end
         ASR: begin
            nxt_o      = {{STEP{cur_i[WIDTH-1]}}, cur_i[WIDTH-1:STEP]};
            sout_o     = cur_i[STEP-1:0];
            sout_upd_o = 1'b1;
         end
         LOAD:    nxt_o = pdata_i;
         CLEAR:   nxt_o = '0;
         default: nxt_o = cur_i;
      endcase
   end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with direct single-cycle operation and counted bursts
// via start/busy/done. Optional parity output enabled by defining SHREG_PARITY_EN.
module univ_shift_reg
   import shreg_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int STEP  = 1,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  shreg_mode_e      mode,
   input  logic [STEP-1:0]  din,
   input  logic [WIDTH-1:0] pdata,
   input  logic             start,
   input  logic [CNT_W-1:0] count,
   output logic [WIDTH-1:0] out,
   output logic [STEP-1:0]  sout,
   output logic             busy,
   output logic             done
`ifdef SHREG_PARITY_EN
   ,
   output logic             par
`endif
);

   if (WIDTH < 2 || STEP < 1 || STEP >= WIDTH || (WIDTH % STEP) != 0) begin : g_bad_cfg
      $error("univ_shift_reg: illegal WIDTH/STEP combination");
   end

   shreg_state_e     state_q, state_d;
   shreg_mode_e      mode_q, mode_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic [STEP-1:0]  sout_q, sout_d;
   logic             done_q, done_d;

   shreg_mode_e      op_mode;
   logic [WIDTH-1:0] step_nxt;
   logic [STEP-1:0]  step_sout;
   logic             step_upd;

   // A burst uses the mode latched at start; direct operation uses the live input.
   assign op_mode = (state_q == RUN) ? mode_q : mode;

   shreg_step_unit #(.WIDTH(WIDTH), .STEP(STEP)) u_step (
      .cur_i      (out_q),
      .mode_i     (op_mode),
      .din_i      (din),
      .pdata_i    (pdata),
      .nxt_o      (step_nxt),
      .sout_o     (step_sout),
      .sout_upd_o (step_upd)
   );

   // State/data registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         mode_q  <= HOLD;
         rem_q   <= '0;
         out_q   <= '0;
         sout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         rem_q   <= rem_d;
         out_q   <= out_d;
         sout_q  <= sout_d;
         done_q  <= done_d;
      end
   end

   // Next-state: start beats direct op in IDLE; RUN applies mode_q on each enabled edge.
   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      rem_d   = rem_q;
      out_d   = out_q;
      sout_d  = sout_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (count != '0) begin
                  mode_d  = mode;
                  rem_d   = count;
                  state_d = RUN;
               end else begin
                  done_d = 1'b1;
               end
            end else if (en) begin
               out_d = step_nxt;
               if (step_upd) sout_d = step_sout;
            end
         end
         RUN: begin
            if (en) begin
               out_d = step_nxt;
               if (step_upd) sout_d = step_sout;
               rem_d = rem_q - 1'b1;
               if (rem_q == CNT_W'(1)) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out  = out_q;
   assign sout = sout_q;
   assign busy = (state_q == RUN);
   assign done = done_q;

`ifdef SHREG_PARITY_EN
   assign par = ^out_q;
`endif

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench: table-driven direct ops on WIDTH=8 with STEP=1 and STEP=2,
// plus hand-written burst, stall, zero-count and reset-abort sequences.
module tb_univ_shift_reg;
   import shreg_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // DUT 1: WIDTH=8, STEP=1
   logic        en1, start1, din1, sout1, busy1, done1;
   shreg_mode_e mode1;
   logic [7:0]  pdata1, out1;
   logic [3:0]  count1;
   // DUT 2: WIDTH=8, STEP=2
   logic        en2, start2, busy2, done2;
   shreg_mode_e mode2;
   logic [1:0]  din2, sout2;
   logic [7:0]  pdata2, out2;
   logic [3:0]  count2;

   univ_shift_reg #(.WIDTH(8), .STEP(1)) d1 (
      .clk(clk), .rst(rst), .en(en1), .mode(mode1), .din(din1), .pdata(pdata1),
      .start(start1), .count(count1), .out(out1), .sout(sout1), .busy(busy1), .done(done1));

   univ_shift_reg #(.WIDTH(8), .STEP(2)) d2 (
      .clk(clk), .rst(rst), .en(en2), .mode(mode2), .din(din2), .pdata(pdata2),
      .start(start2), .count(count2), .out(out2), .sout(sout2), .busy(busy2), .done(done2));

   typedef struct {
      shreg_mode_e m;
      logic [1:0]  din;
      logic [7:0]  pd;
      logic [7:0]  eo;
      logic [1:0]  es;
   } vec_t;

   vec_t v1[12];
   vec_t v2[7];
   int checks = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk1(input string nm, input logic [7:0] o, input logic b, input logic d);
      chk({nm, ".out"}, 32'(out1), 32'(o));
      chk({nm, ".busy"}, 32'(busy1), 32'(b));
      chk({nm, ".done"}, 32'(done1), 32'(d));
   endtask

   initial begin
      // STEP=1 direct-mode vectors (expected values after the edge)
      v1[0]  = '{LOAD,  2'd0, 8'hA5, 8'hA5, 2'd0};
      v1[1]  = '{SHL,   2'd1, 8'h00, 8'h4B, 2'd1};
      v1[2]  = '{SHR,   2'd0, 8'h00, 8'h25, 2'd1};
      v1[3]  = '{HOLD,  2'd1, 8'hFF, 8'h25, 2'd1};
      v1[4]  = '{ROL,   2'd1, 8'h00, 8'h4A, 2'd0};
      v1[5]  = '{ROR,   2'd1, 8'h00, 8'h25, 2'd0};
      v1[6]  = '{ASR,   2'd0, 8'h00, 8'h12, 2'd1};
      v1[7]  = '{LOAD,  2'd0, 8'h80, 8'h80, 2'd1};
      v1[8]  = '{ASR,   2'd0, 8'h00, 8'hC0, 2'd0};
      v1[9]  = '{CLEAR, 2'd1, 8'h00, 8'h00, 2'd0};
      v1[10] = '{LOAD,  2'd0, 8'hFF, 8'hFF, 2'd0};
      v1[11] = '{SHL,   2'd0, 8'h00, 8'hFE, 2'd1};
      // STEP=2 direct-mode vectors
      v2[0]  = '{LOAD,  2'b00, 8'h81, 8'h81, 2'b00};
      v2[1]  = '{ROR,   2'b00, 8'h00, 8'h60, 2'b01};
      v2[2]  = '{ROL,   2'b00, 8'h00, 8'h81, 2'b01};
      v2[3]  = '{SHL,   2'b11, 8'h00, 8'h07, 2'b10};
      v2[4]  = '{LOAD,  2'b00, 8'h90, 8'h90, 2'b10};
      v2[5]  = '{ASR,   2'b00, 8'h00, 8'hE4, 2'b00};
      v2[6]  = '{SHR,   2'b01, 8'h00, 8'h79, 2'b00};

      // Reset held 3 cycles with everything else trying to act
      rst = 1'b0;
      en1 = 1'b1; mode1 = SHL; din1 = 1'b1; pdata1 = 8'hFF; start1 = 1'b1; count1 = 4'd3;
      en2 = 1'b1; mode2 = SHL; din2 = 2'b11; pdata2 = 8'hFF; start2 = 1'b1; count2 = 4'd3;
      repeat (3) tick();
      chk("rst.out1", 32'(out1), 32'h0);
      chk("rst.sout1", 32'(sout1), 32'h0);
      chk("rst.busy1", 32'(busy1), 32'h0);
      chk("rst.done1", 32'(done1), 32'h0);
      chk("rst.out2", 32'(out2), 32'h0);
      chk("rst.sout2", 32'(sout2), 32'h0);
      chk("rst.busy2", 32'(busy2), 32'h0);
      chk("rst.done2", 32'(done2), 32'h0);
      rst = 1'b1;
      start1 = 1'b0; start2 = 1'b0; en1 = 1'b0; en2 = 1'b0;
      mode1 = HOLD; mode2 = HOLD;
      tick();

      // Table-driven direct operations
      en1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         mode1 = v1[i].m; din1 = v1[i].din[0]; pdata1 = v1[i].pd;
         tick();
         chk($sformatf("v1[%0d].out", i), 32'(out1), 32'(v1[i].eo));
         chk($sformatf("v1[%0d].sout", i), 32'(sout1), 32'(v1[i].es[0]));
      end
      en1 = 1'b0;
      en2 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         mode2 = v2[i].m; din2 = v2[i].din; pdata2 = v2[i].pd;
         tick();
         chk($sformatf("v2[%0d].out", i), 32'(out2), 32'(v2[i].eo));
         chk($sformatf("v2[%0d].sout", i), 32'(sout2), 32'(v2[i].es));
      end
      en2 = 1'b0; mode2 = HOLD;

      // Burst ASR x3 from 0x80; mode change during RUN must be ignored
      en1 = 1'b1; mode1 = LOAD; pdata1 = 8'h80; tick();
      start1 = 1'b1; count1 = 4'd3; mode1 = ASR; tick();
      chk1("asr.e0", 8'h80, 1'b1, 1'b0);
      start1 = 1'b0; mode1 = SHL; din1 = 1'b0; tick();
      chk1("asr.e1", 8'hC0, 1'b1, 1'b0);
      tick();
      chk1("asr.e2", 8'hE0, 1'b1, 1'b0);
      mode1 = HOLD; tick();
      chk1("asr.e3", 8'hF0, 1'b0, 1'b1);
      tick();
      chk1("asr.e4", 8'hF0, 1'b0, 1'b0);

      // Burst SHR x4 with a 2-cycle stall and an ignored start during busy
      mode1 = LOAD; pdata1 = 8'hF0; tick();
      start1 = 1'b1; count1 = 4'd4; mode1 = SHR; din1 = 1'b0; tick();
      chk1("shr.e0", 8'hF0, 1'b1, 1'b0);
      start1 = 1'b0; tick();
      chk1("shr.e1", 8'h78, 1'b1, 1'b0);
      en1 = 1'b0; start1 = 1'b1; count1 = 4'd1; mode1 = LOAD; tick();
      chk1("shr.stall1", 8'h78, 1'b1, 1'b0);
      start1 = 1'b0; tick();
      chk1("shr.stall2", 8'h78, 1'b1, 1'b0);
      en1 = 1'b1; tick();
      chk1("shr.e4", 8'h3C, 1'b1, 1'b0);
      tick();
      chk1("shr.e5", 8'h1E, 1'b1, 1'b0);
      mode1 = HOLD; tick();
      chk1("shr.e6", 8'h0F, 1'b0, 1'b1);
      chk("shr.sout", 32'(sout1), 32'h0);
      tick();
      chk1("shr.e7", 8'h0F, 1'b0, 1'b0);

      // count=0: immediate done pulse, no busy, out unchanged (start beats SHL)
      start1 = 1'b1; count1 = 4'd0; mode1 = SHL; din1 = 1'b1; tick();
      chk1("cnt0.e0", 8'h0F, 1'b0, 1'b1);
      start1 = 1'b0; mode1 = HOLD; tick();
      chk1("cnt0.e1", 8'h0F, 1'b0, 1'b0);

      // Reset mid-burst aborts with no done
      start1 = 1'b1; count1 = 4'd3; mode1 = SHL; din1 = 1'b1; tick();
      start1 = 1'b0; tick();
      chk1("abort.run", 8'h1F, 1'b1, 1'b0);
      rst = 1'b0; tick();
      chk1("abort.rst", 8'h00, 1'b0, 1'b0);
      rst = 1'b1; mode1 = HOLD; tick();
      chk1("abort.p1", 8'h00, 1'b0, 1'b0);
      tick();
      chk1("abort.p2", 8'h00, 1'b0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
